// File: rtl/joy_db15_pkg.sv
// Shared types and constants for the DB15 serial joystick responder.
package joy_db15_pkg;

  localparam int DEFAULT_BITS_PER_PLAYER = 12;
  localparam int DEFAULT_TIMEOUT_CYCLES  = 1048576;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_IDLE  = 2'd2
  } state_t;

  // Button bit positions within one player's word (LS FEDCBAUDLR).
  localparam int BTN_RIGHT  = 0;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_UP     = 3;
  localparam int BTN_A      = 4;
  localparam int BTN_B      = 5;
  localparam int BTN_C      = 6;
  localparam int BTN_D      = 7;
  localparam int BTN_E      = 8;
  localparam int BTN_F      = 9;
  localparam int BTN_START  = 10;
  localparam int BTN_SELECT = 11;

endpackage

// File: rtl/joy_sync.sv
// Two-flop synchronizer for asynchronous host pins; idles high out of reset.
module joy_sync #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: non-blocking assignments make both stages sample the old values, so this stays two flops deep.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/joy_db15_tx.sv
// DB15 joystick responder: latches two players' buttons on the host strobe
// and shifts them out, P1 bit 0 first, one bit per host clock rising edge.
module joy_db15_tx
  import joy_db15_pkg::*;
#(
  parameter int BITS_PER_PLAYER = DEFAULT_BITS_PER_PLAYER,
  parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] joy1,
  input  logic [15:0] joy2,
  input  logic        joy_load,
  input  logic        joy_clk,
  output logic        joy_data,
  output logic        frame_done,
  output logic        link_active
);

  localparam int FRAME_BITS = 2 * BITS_PER_PLAYER;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam int WD_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT_CYCLES);

  logic                  load_s, clk_s;
  logic                  load_q, clk_q;
  logic                  load_fall, load_rise, clk_rise;
  state_t                state, state_next;
  logic                  shift_en;
  logic [FRAME_BITS-1:0] shreg;
  logic [CNT_W-1:0]      cnt;
  logic [WD_W-1:0]       wd;
  logic                  seen;
  logic                  unused_hi_bits;

  assign unused_hi_bits = ^{joy1[15:BITS_PER_PLAYER], joy2[15:BITS_PER_PLAYER]};

  joy_sync #(.WIDTH(1)) u_load_sync (
    .clk   (clk),
    .reset (reset),
    .d     (joy_load),
    .q     (load_s)
  );

  joy_sync #(.WIDTH(1)) u_clk_sync (
    .clk   (clk),
    .reset (reset),
    .d     (joy_clk),
    .q     (clk_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_q <= 1'b1;
      clk_q  <= 1'b1;
    end else begin
      load_q <= load_s;
      clk_q  <= clk_s;
    end
  end

  assign load_fall = load_q & ~load_s;
  assign load_rise = ~load_q & load_s;
  assign clk_rise  = ~clk_q & clk_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // NOTE: assign every output a default first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      ST_LOAD:  if (load_rise) state_next = ST_SHIFT;
      ST_SHIFT: begin
        if (load_fall)            state_next = ST_LOAD;
        else if (cnt == CNT_LAST) state_next = ST_IDLE;
      end
      ST_IDLE:  if (load_fall) state_next = ST_LOAD;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Load edges win over a coincident clock edge, which is then dropped.
  always_comb begin
    shift_en   = 1'b0;
    frame_done = 1'b0;
    if (state == ST_SHIFT) begin
      frame_done = (cnt == CNT_LAST);
      shift_en   = clk_rise & ~load_fall & ~load_rise & (cnt != CNT_LAST);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg <= '0;
      cnt   <= '0;
    end else begin
      if (state == ST_LOAD)
        shreg <= {joy2[BITS_PER_PLAYER-1:0], joy1[BITS_PER_PLAYER-1:0]};
      else if (shift_en)
        shreg <= {1'b0, shreg[FRAME_BITS-1:1]};

      if (state_next == ST_LOAD) cnt <= '0;
      else if (shift_en)         cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) joy_data <= 1'b1;
    else       joy_data <= (state == ST_IDLE) ? 1'b1 : ~shreg[0];
  end

  // Watchdog restarts on every latch and parks at its limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd   <= WD_MAX;
      seen <= 1'b0;
    end else if (load_fall) begin
      wd   <= '0;
      seen <= 1'b1;
    end else if (wd != WD_MAX) begin
      wd   <= wd + WD_W'(1);
    end
  end

  assign link_active = seen & (wd < WD_MAX);

endmodule

// File: tb/tb_joy_db15_tx.sv
// Directed-plus-random bench for joy_db15_tx acting as a host reader.
module tb_joy_db15_tx;
  import joy_db15_pkg::*;

  localparam int BPP     = 12;
  localparam int NBITS   = 2 * BPP;
  localparam int TIMEOUT = 64;
  localparam int HOLD    = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] joy1 = '0;
  logic [15:0] joy2 = '0;
  logic        joy_load = 1'b1;
  logic        joy_clk = 1'b0;
  logic        joy_data, frame_done, link_active;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;
  int fd_count = 0;
  int fd_cyc = -1;
  int last_rise = 0;

  joy_db15_tx #(
    .BITS_PER_PLAYER (BPP),
    .TIMEOUT_CYCLES  (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .joy1        (joy1),
    .joy2        (joy2),
    .joy_load    (joy_load),
    .joy_clk     (joy_clk),
    .joy_data    (joy_data),
    .frame_done  (frame_done),
    .link_active (link_active)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      fd_count <= fd_count + 1;
      fd_cyc   <= cyc;
    end
  end

  initial begin
    #20000000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "bench time limit expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pin level the host should read for frame bit i: pressed reads 0, past the frame reads 1.
  function automatic logic exp_bit(input logic [15:0] j1, input logic [15:0] j2, input int i);
    if (i < BPP)   return ~j1[i];
    if (i < NBITS) return ~j2[i - BPP];
    return 1'b1;
  endfunction

  task automatic do_latch(input logic [15:0] j1, input logic [15:0] j2);
    joy1     = j1;
    joy2     = j2;
    joy_load = 1'b0;
    tick(HOLD);
    joy_load = 1'b1;
    tick(HOLD);
  endtask

  task automatic shift_frame(input logic [15:0] j1, input logic [15:0] j2,
                             input int first, input int last, input string tag);
    for (int i = first; i <= last; i++) begin
      if (i > 0) begin
        joy_clk = 1'b1;
        if (i == NBITS) last_rise = cyc;
        tick(HOLD);
      end
      check($sformatf("%s_bit%0d", tag, i), {31'd0, joy_data}, {31'd0, exp_bit(j1, j2, i)});
      if (i > 0) begin
        joy_clk = 1'b0;
        tick(HOLD);
      end
    end
  endtask

  task automatic full_frame(input logic [15:0] j1, input logic [15:0] j2,
                            input int pulses, input string tag);
    int fd0;
    fd0 = fd_count;
    do_latch(j1, j2);
    shift_frame(j1, j2, 0, pulses, tag);
    check({tag, "_fd_count"}, fd_count - fd0, 1);
    check({tag, "_fd_time"}, fd_cyc, last_rise + 3);
  endtask

  initial begin
    logic [15:0] ja, jb, jc;
    int c0, fd0;

    // Reset state, both while held and just after release.
    tick(3);
    check("rst_joy_data", {31'd0, joy_data}, 1);
    check("rst_frame_done", {31'd0, frame_done}, 0);
    check("rst_link", {31'd0, link_active}, 0);
    reset = 1'b0;
    tick(4);
    check("post_rst_link", {31'd0, link_active}, 0);

    // IDLE ignores host clock edges.
    joy_clk = 1'b1;
    tick(HOLD);
    check("idle_clk_data", {31'd0, joy_data}, 1);
    joy_clk = 1'b0;
    tick(HOLD);
    check("idle_clk_fd", fd_count, 0);

    // Watchdog: one latch, then silence.
    joy_load = 1'b0;
    c0 = cyc;
    for (int k = 1; k <= TIMEOUT + 3; k++) begin
      tick(1);
      if (cyc - c0 == 2)           check("wd_before_rise", {31'd0, link_active}, 0);
      if (cyc - c0 == 3)           check("wd_rise", {31'd0, link_active}, 1);
      if (cyc - c0 == TIMEOUT + 2) check("wd_last_high", {31'd0, link_active}, 1);
      if (cyc - c0 == TIMEOUT + 3) check("wd_fall", {31'd0, link_active}, 0);
      if (k == HOLD) joy_load = 1'b1;
    end

    // Full frame with R on P1 and A on P2.
    full_frame(16'h0001, 16'h0010, NBITS, "full");

    // Over-clocking past the end of the frame.
    full_frame(16'($urandom), 16'($urandom), NBITS + 6, "over");

    // Random button words.
    for (int r = 0; r < 3; r++)
      full_frame(16'($urandom), 16'($urandom), NBITS, $sformatf("rand%0d", r));

    // Mid-frame abort, then restart with only select held on P1.
    ja  = 16'($urandom);
    jb  = 16'($urandom);
    fd0 = fd_count;
    do_latch(ja, jb);
    shift_frame(ja, jb, 0, 10, "abort_pre");
    jc = 16'd1 << BTN_SELECT;
    full_frame(jc, jb, NBITS, "abort_new");
    check("abort_fd_total", fd_count - fd0, 1);

    // Load fall and clock rise in the same synced cycle.
    ja = 16'($urandom);
    jb = 16'($urandom);
    do_latch(ja, jb);
    shift_frame(ja, jb, 0, 5, "sim_pre");
    fd0 = fd_count;
    jc = ~ja;
    joy1     = jc;
    joy_load = 1'b0;
    joy_clk  = 1'b1;
    tick(HOLD);
    check("sim_load_data", {31'd0, joy_data}, {31'd0, ~jc[0]});
    joy_clk = 1'b0;
    tick(HOLD);
    joy_load = 1'b1;
    tick(HOLD);
    shift_frame(jc, jb, 0, NBITS, "sim_new");
    check("sim_fd_total", fd_count - fd0, 1);

    // Reset mid-frame, with bit 5 pressed so the output is low beforehand.
    ja = 16'($urandom) | 16'h0020;
    jb = 16'($urandom);
    do_latch(ja, jb);
    shift_frame(ja, jb, 0, 5, "rst_pre");
    reset = 1'b1;
    #1;
    check("mid_rst_data", {31'd0, joy_data}, 1);
    check("mid_rst_fd", {31'd0, frame_done}, 0);
    check("mid_rst_link", {31'd0, link_active}, 0);
    tick(3);
    reset = 1'b0;
    tick(4);
    check("mid_rst_idle_data", {31'd0, joy_data}, 1);
    full_frame(16'($urandom), 16'($urandom), NBITS, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
